// File: rtl/and_gate_unit_pkg.sv
// Shared constants for integrators of the AND datapath leaf block.
package and_gate_unit_pkg;

    // Default operand/result width
    localparam int AND_W     = 1;
    // Default width of the nonzero-result event counter
    localparam int AND_CNT_W = 16;

endpackage

// File: rtl/and_gate_unit_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment)
// and asynchronous active-low reset. Stops at all-ones instead of wrapping.
module and_gate_unit_sat_counter
    import and_gate_unit_pkg::*;
#(
    parameter int CNT_W = AND_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_p1;

    // Next value of an increment: hold once the counter is at full scale
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        return (&val) ? val : val + CNT_ONE;
    endfunction

    // Counter register: clear has priority, then saturating increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_p1 <= '0;
        end else if (clr) begin
            count_p1 <= '0;
        end else if (inc) begin
            count_p1 <= sat_inc(count_p1);
        end
    end

    assign count = count_p1;

endmodule

// File: rtl/and_gate_unit.sv
// Bitwise AND leaf: zero-latency result with reduction flags, a one-cycle
// registered copy qualified by a valid pulse, and a saturating count of
// accepted operations whose result was nonzero.
module and_gate_unit
    import and_gate_unit_pkg::*;
#(
    parameter int WIDTH = AND_W,
    parameter int CNT_W = AND_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             cnt_clr,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] c_q,
    output logic             out_valid,
    output logic             all_ones,
    output logic             any_one,
    output logic [CNT_W-1:0] nz_count
);

    logic [WIDTH-1:0] c_p1;
    logic             vld_p1;

    // Stage 0: combinational AND and reduction flags, independent of clk/rst_n
    assign c        = a & b;
    assign all_ones = &c;
    assign any_one  = |c;

    // Stage 0 -> 1: capture result on in_valid; valid is a one-cycle pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_p1   <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                c_p1 <= c;
            end
        end
    end

    assign c_q       = c_p1;
    assign out_valid = vld_p1;

    and_gate_unit_sat_counter #(
        .CNT_W (CNT_W)
    ) u_nz_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (in_valid & any_one),
        .clr   (cnt_clr),
        .count (nz_count)
    );

endmodule

// File: tb/tb_and_gate_unit.sv
// Bench for and_gate_unit: a WIDTH=1 instance for the truth table and
// asynchronous reset, a WIDTH=8/CNT_W=2 instance checked against a
// behavioural model under directed and random stimulus.
module tb_and_gate_unit;

    logic clk;
    logic rst_n;

    // WIDTH=1, CNT_W=16 instance
    logic        a1, b1, iv1, clr1;
    logic        c1, cq1, ov1, ao1, an1;
    logic [15:0] cnt1;

    // WIDTH=8, CNT_W=2 instance
    logic [7:0] a8, b8;
    logic       iv8, clr8;
    logic [7:0] c8, cq8;
    logic       ov8, ao8, an8;
    logic [1:0] cnt8;

    int checks   = 0;
    int failures = 0;

    // Model of the 8-bit instance
    logic [7:0] m_cq;
    logic       m_ov;
    int         m_cnt;

    and_gate_unit #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(iv1), .cnt_clr(clr1),
        .c(c1), .c_q(cq1), .out_valid(ov1), .all_ones(ao1), .any_one(an1), .nz_count(cnt1)
    );

    and_gate_unit #(.WIDTH(8), .CNT_W(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(iv8), .cnt_clr(clr8),
        .c(c8), .c_q(cq8), .out_valid(ov8), .all_ones(ao8), .any_one(an8), .nz_count(cnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One operation on the 8-bit instance; entered and left at a falling edge
    task automatic step8(input logic [7:0] ta, input logic [7:0] tb_, input logic tiv, input logic tclr);
        logic [7:0] prod;
        prod = ta & tb_;
        a8 = ta; b8 = tb_; iv8 = tiv; clr8 = tclr;
        #1;
        check_val("c8", 32'(c8), 32'(prod));
        check_val("all_ones8", 32'(ao8), 32'(prod == 8'hFF));
        check_val("any_one8", 32'(an8), 32'(prod != 8'h00));
        @(posedge clk);
        if (tiv) m_cq = prod;
        m_ov = tiv;
        if (tclr) m_cnt = 0;
        else if (tiv && prod != 8'h00) m_cnt = (m_cnt < 3) ? m_cnt + 1 : 3;
        @(negedge clk);
        check_val("c_q8", 32'(cq8), 32'(m_cq));
        check_val("out_valid8", 32'(ov8), 32'(m_ov));
        check_val("nz_count8", 32'(cnt8), 32'(m_cnt));
    endtask

    initial begin
        logic [1:0] ab;
        logic [7:0] ra, rb;
        rst_n = 1'b0;
        a1 = 1'b0; b1 = 1'b0; iv1 = 1'b0; clr1 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; iv8 = 1'b0; clr8 = 1'b0;
        m_cq = 8'h00; m_ov = 1'b0; m_cnt = 0;

        // Reset state
        #1;
        check_val("rst_c_q1", 32'(cq1), 32'd0);
        check_val("rst_out_valid1", 32'(ov1), 32'd0);
        check_val("rst_nz_count1", 32'(cnt1), 32'd0);
        check_val("rst_c_q8", 32'(cq8), 32'd0);
        check_val("rst_out_valid8", 32'(ov8), 32'd0);
        check_val("rst_nz_count8", 32'(cnt8), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=1 truth table, one change every 10 time units
        for (int i = 0; i < 4; i++) begin
            ab = 2'(i);
            a1 = ab[1]; b1 = ab[0];
            #1;
            check_val("tt_c1", 32'(c1), 32'(i == 3));
            check_val("tt_any1", 32'(an1), 32'(i == 3));
            check_val("tt_all1", 32'(ao1), 32'(i == 3));
            #9;
        end

        // Build c_q=1, out_valid=1, nz_count=3, then reset mid-cycle
        a1 = 1'b1; b1 = 1'b1; iv1 = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        check_val("pre_c_q1", 32'(cq1), 32'd1);
        check_val("pre_out_valid1", 32'(ov1), 32'd1);
        check_val("pre_nz_count1", 32'(cnt1), 32'd3);
        rst_n = 1'b0;
        #1;
        check_val("arst_c_q1", 32'(cq1), 32'd0);
        check_val("arst_out_valid1", 32'(ov1), 32'd0);
        check_val("arst_nz_count1", 32'(cnt1), 32'd0);
        check_val("arst_c1_hi", 32'(c1), 32'd1);
        a1 = 1'b0;
        #1;
        check_val("arst_c1_lo", 32'(c1), 32'd0);
        iv1 = 1'b0;
        m_cq = 8'h00; m_ov = 1'b0; m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // WIDTH=8 directed burst
        step8(8'hF0, 8'h3C, 1'b1, 1'b0);
        check_val("burst_c_q_30", 32'(cq8), 32'h30);
        step8(8'hFF, 8'hFF, 1'b1, 1'b0);
        check_val("burst_c_q_ff", 32'(cq8), 32'hFF);
        step8(8'h0F, 8'hF0, 1'b1, 1'b0);
        check_val("burst_c_q_00", 32'(cq8), 32'h00);
        check_val("burst_nz_count", 32'(cnt8), 32'd2);

        // Saturation at 3 over seven nonzero results
        step8(8'h00, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step8(8'h81, 8'h01, 1'b1, 1'b0);
            check_val("sat_nz_count", 32'(cnt8), 32'((i < 3) ? i + 1 : 3));
        end

        // Clear beats a simultaneous increment from nz_count=2
        step8(8'h00, 8'h00, 1'b0, 1'b1);
        step8(8'h11, 8'h10, 1'b1, 1'b0);
        step8(8'h22, 8'h20, 1'b1, 1'b0);
        check_val("clr_pre_count", 32'(cnt8), 32'd2);
        step8(8'hAA, 8'hAA, 1'b1, 1'b1);
        check_val("clr_count", 32'(cnt8), 32'd0);
        check_val("clr_c_q", 32'(cq8), 32'hAA);
        check_val("clr_out_valid", 32'(ov8), 32'd1);

        // Inputs toggling with in_valid low
        for (int i = 0; i < 4; i++) begin
            step8(8'($urandom), 8'($urandom), 1'b0, 1'b0);
            check_val("idle_c_q", 32'(cq8), 32'hAA);
        end

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                ra = 8'hFF; rb = 8'hFF;
            end
            step8(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
